// File: rtl/rtc_timer_gen2.sv
// Time-of-day counter: prescaler feeding cascaded sec/min/hour counters with nested tick pulses.
// Optional alarm compare and sticky flag are built when TIMER_ALARM_EN is defined.
module rtc_timer_gen2 #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int SEC_PER_MIN  = 60,
  parameter int MIN_PER_HOUR = 60,
  parameter int HOUR_PER_DAY = 24,
  parameter int PRE_W        = 26,
  localparam int SEC_W  = $clog2(SEC_PER_MIN),
  localparam int MIN_W  = $clog2(MIN_PER_HOUR),
  localparam int HOUR_W = $clog2(HOUR_PER_DAY)
) (
  input  logic              clk_50m,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              load,
  input  logic [SEC_W-1:0]  load_sec,
  input  logic [MIN_W-1:0]  load_min,
  input  logic [HOUR_W-1:0] load_hour,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              sec_tick,
  output logic              min_tick,
  output logic              hour_tick,
  output logic              day_tick,
  output logic              load_err,
  input  logic [SEC_W-1:0]  alarm_sec,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic              alarm_arm,
  input  logic              alarm_ack,
  output logic              alarm_pulse,
  output logic              alarm_hit
);

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [MIN_W-1:0]  MIN_MAX  = MIN_W'(MIN_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_PER_DAY - 1);

  logic [PRE_W-1:0]  pre;
  logic [PRE_W-1:0]  cnt_pre;
  logic [SEC_W-1:0]  cnt_sec;
  logic [MIN_W-1:0]  cnt_min;
  logic [HOUR_W-1:0] cnt_hour;
  logic              pre_wrap, sec_wrap, min_wrap, hour_wrap;
  logic              sec_ok, min_ok, hour_ok;

  // Next time assuming a counting edge; each wrap gates the one above it.
  always_comb begin
    pre_wrap  = (pre == PRE_MAX);
    sec_wrap  = pre_wrap && (sec == SEC_MAX);
    min_wrap  = sec_wrap && (min == MIN_MAX);
    hour_wrap = min_wrap && (hour == HOUR_MAX);
    cnt_pre   = pre_wrap ? '0 : pre + 1'b1;
    cnt_sec   = sec;
    cnt_min   = min;
    cnt_hour  = hour;
    if (pre_wrap) cnt_sec  = sec_wrap  ? '0 : sec + 1'b1;
    if (sec_wrap) cnt_min  = min_wrap  ? '0 : min + 1'b1;
    if (min_wrap) cnt_hour = hour_wrap ? '0 : hour + 1'b1;
    sec_ok  = (load_sec  <= SEC_MAX);
    min_ok  = (load_min  <= MIN_MAX);
    hour_ok = (load_hour <= HOUR_MAX);
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      pre       <= '0;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      day_tick  <= 1'b0;
      load_err  <= 1'b0;
      if (clear) begin
        pre  <= '0;
        sec  <= '0;
        min  <= '0;
        hour <= '0;
      end else if (load) begin
        pre      <= '0;
        sec      <= sec_ok  ? load_sec  : '0;
        min      <= min_ok  ? load_min  : '0;
        hour     <= hour_ok ? load_hour : '0;
        load_err <= !(sec_ok && min_ok && hour_ok);
      end else if (enable) begin
        pre       <= cnt_pre;
        sec       <= cnt_sec;
        min       <= cnt_min;
        hour      <= cnt_hour;
        sec_tick  <= pre_wrap;
        min_tick  <= sec_wrap;
        hour_tick <= min_wrap;
        day_tick  <= hour_wrap;
      end
    end
  end

`ifdef TIMER_ALARM_EN
  logic alarm_match;

  assign alarm_match = pre_wrap && alarm_arm &&
                       ({cnt_hour, cnt_min, cnt_sec} == {alarm_hour, alarm_min, alarm_sec});

  // A fresh hit outranks a simultaneous acknowledge.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      alarm_pulse <= 1'b0;
      alarm_hit   <= 1'b0;
    end else begin
      alarm_pulse <= 1'b0;
      if (clear) begin
        alarm_hit <= 1'b0;
      end else if (!load && enable && alarm_match) begin
        alarm_pulse <= 1'b1;
        alarm_hit   <= 1'b1;
      end else if (alarm_ack) begin
        alarm_hit <= 1'b0;
      end
    end
  end
`else
  logic unused_alarm;

  assign unused_alarm = ^{alarm_sec, alarm_min, alarm_hour, alarm_arm, alarm_ack};
  assign alarm_pulse  = 1'b0;
  assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timer_gen2.sv
// Bench for rtc_timer_gen2 (TICK_DIV=5): vector table, hand sequences and random run
// against a seconds-of-day reference model.
module tb_rtc_timer_gen2;
  localparam int TD = 5;
  localparam int DAY = 24 * 3600;

  logic       clk_50m = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, clear = 1'b0, load = 1'b0;
  logic [5:0] load_sec = '0, load_min = '0;
  logic [4:0] load_hour = '0;
  logic [5:0] alarm_sec = '0, alarm_min = '0;
  logic [4:0] alarm_hour = '0;
  logic       alarm_arm = 1'b0, alarm_ack = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       sec_tick, min_tick, hour_tick, day_tick, load_err, alarm_pulse, alarm_hit;

  rtc_timer_gen2 #(.TICK_DIV(TD)) dut (
    .clk_50m(clk_50m), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
    .sec(sec), .min(min), .hour(hour),
    .sec_tick(sec_tick), .min_tick(min_tick), .hour_tick(hour_tick), .day_tick(day_tick),
    .load_err(load_err),
    .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack),
    .alarm_pulse(alarm_pulse), .alarm_hit(alarm_hit)
  );

  always #10 clk_50m = ~clk_50m;

  int total = 0;
  int bad = 0;

  // Reference model: prescaler phase plus time as a single seconds-of-day count.
  int       m_pre = 0, m_tod = 0;
  bit [3:0] m_ticks = '0;
  bit       m_err = 0, m_apulse = 0, m_ahit = 0;

  task automatic model_reset();
    m_pre = 0; m_tod = 0; m_ticks = '0; m_err = 0; m_apulse = 0; m_ahit = 0;
  endtask

  task automatic model_edge();
    int s, m, h;
    m_ticks = '0; m_err = 0; m_apulse = 0;
    if (clear) begin
      m_pre = 0; m_tod = 0; m_ahit = 0;
    end else if (load) begin
      s = (load_sec < 60) ? int'(load_sec) : 0;
      m = (load_min < 60) ? int'(load_min) : 0;
      h = (load_hour < 24) ? int'(load_hour) : 0;
      m_err = (load_sec >= 60) || (load_min >= 60) || (load_hour >= 24);
      m_tod = h * 3600 + m * 60 + s;
      m_pre = 0;
      if (alarm_ack) m_ahit = 0;
    end else begin
      if (enable) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          m_tod = (m_tod + 1) % DAY;
          m_ticks = {m_tod == 0, m_tod % 3600 == 0, m_tod % 60 == 0, 1'b1};
`ifdef TIMER_ALARM_EN
          if (alarm_arm && (m_tod % 60 == int'(alarm_sec)) && ((m_tod / 60) % 60 == int'(alarm_min))
              && (m_tod / 3600 == int'(alarm_hour)))
            m_apulse = 1;
`endif
        end else begin
          m_pre++;
        end
      end
      if (m_apulse) m_ahit = 1;
      else if (alarm_ack) m_ahit = 0;
    end
  endtask

  task automatic check_model(input string name);
    logic [29:0] got, exp;
    got = {sec, min, hour, day_tick, hour_tick, min_tick, sec_tick, load_err, alarm_pulse, alarm_hit};
    exp = {6'(m_tod % 60), 6'((m_tod / 60) % 60), 5'(m_tod / 3600), m_ticks, m_err, m_apulse, m_ahit};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk_50m);
    model_edge();
    #1;
    check_model(name);
  endtask

  typedef struct {
    bit       clr, ld, en;
    int       ls, lm, lh, n;
    int       es, em, eh;
    bit [3:0] et;
    bit       ee;
  } vec_t;

  function automatic vec_t mk(bit clr, bit ld, bit en, int ls, int lm, int lh, int n,
                              int es, int em, int eh, bit [3:0] et, bit ee);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.ls = ls; v.lm = lm; v.lh = lh; v.n = n;
    v.es = es; v.em = em; v.eh = eh; v.et = et; v.ee = ee;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Expected state after the last cycle of each row; ticks are {day,hour,min,sec}.
    tbl.push_back(mk(0,0,1,  0, 0, 0, 5,   1, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 20,  5, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(0,1,0, 59, 0, 0, 1,  59, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 5,   0, 1, 0, 4'b0011, 0));
    tbl.push_back(mk(0,1,1, 59,59,23, 1,  59,59,23, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 5,   0, 0, 0, 4'b1111, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 1,   0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,1,1, 60, 5, 3, 1,   0, 5, 3, 4'b0000, 1));
    tbl.push_back(mk(0,0,0,  0, 0, 0, 20,  0, 5, 3, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 3,   0, 5, 3, 4'b0000, 0));
    tbl.push_back(mk(1,1,1, 59,59,23, 1,   0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 4,   0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 1,   1, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 2,   1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,0,  0, 0, 0, 10,  1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 2,   1, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 1,   2, 0, 0, 4'b0001, 0));
    tbl.push_back(mk(0,1,0, 59,59,24, 1,  59,59, 0, 4'b0000, 1));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 5,   0, 0, 1, 4'b0111, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 3,   0, 0, 1, 4'b0000, 0));
    tbl.push_back(mk(1,0,0,  0, 0, 0, 1,   0, 0, 0, 4'b0000, 0));
    tbl.push_back(mk(0,0,1,  0, 0, 0, 5,   1, 0, 0, 4'b0001, 0));

    model_reset();
    #5;
    check_model("reset_state");
    @(negedge clk_50m);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      clear = tbl[i].clr; load = tbl[i].ld; enable = tbl[i].en;
      load_sec = 6'(tbl[i].ls); load_min = 6'(tbl[i].lm); load_hour = 5'(tbl[i].lh);
      for (int k = 0; k < tbl[i].n; k++) step($sformatf("row%0d_cyc%0d", i, k));
      clear = 1'b0; load = 1'b0;
      total++;
      if ({sec, min, hour, day_tick, hour_tick, min_tick, sec_tick, load_err} !==
          {6'(tbl[i].es), 6'(tbl[i].em), 5'(tbl[i].eh), tbl[i].et, tbl[i].ee}) begin
        bad++;
        $display("FAIL vec%0d got=%0d:%0d:%0d t=%b e=%b exp=%0d:%0d:%0d t=%b e=%b", i,
                 hour, min, sec, {day_tick, hour_tick, min_tick, sec_tick}, load_err,
                 tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].et, tbl[i].ee);
      end
    end

    // Asynchronous reset mid-count, then a fresh 5-cycle first second.
    enable = 1'b1;
    repeat (7) step("pre_reset");
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    check_bit("async_reset_sec", |sec, 1'b0);
    @(posedge clk_50m);
    @(negedge clk_50m);
    reset_n = 1'b1;
    repeat (4) step("post_reset");
    check_bit("post_reset_no_tick", sec_tick, 1'b0);
    step("post_reset_tick");
    check_bit("post_reset_tick", sec_tick, 1'b1);

    // Alarm at 00:00:03, acknowledged a few cycles after it fires.
    clear = 1'b1;
    step("alarm_clear");
    clear = 1'b0;
    alarm_sec = 6'd3; alarm_min = '0; alarm_hour = '0; alarm_arm = 1'b1;
    begin
      int pulses = 0;
      for (int k = 0; k < 14; k++) begin
        step("alarm_wait");
        pulses += int'(alarm_pulse);
      end
      total++;
      if (pulses != 0) begin
        bad++;
        $display("FAIL alarm_early got=%0d exp=0", pulses);
      end
    end
    step("alarm_edge");
`ifdef TIMER_ALARM_EN
    check_bit("alarm_pulse_15", alarm_pulse, 1'b1);
    repeat (3) step("alarm_hold");
    check_bit("alarm_hit_held", alarm_hit, 1'b1);
    check_bit("alarm_pulse_single", alarm_pulse, 1'b0);
    alarm_ack = 1'b1;
    step("alarm_ack");
    alarm_ack = 1'b0;
    check_bit("alarm_hit_cleared", alarm_hit, 1'b0);
`else
    check_bit("alarm_pulse_tied", alarm_pulse, 1'b0);
    check_bit("alarm_hit_tied", alarm_hit, 1'b0);
`endif

    // Random run; the alarm is periodically aimed one second ahead so it can fire.
    for (int k = 0; k < 600; k++) begin
      clear     = ($urandom % 60) == 0;
      load      = ($urandom % 20) == 0;
      enable    = ($urandom % 5) != 0;
      load_sec  = 6'($urandom_range(0, 63));
      load_min  = 6'($urandom_range(0, 63));
      load_hour = 5'($urandom_range(0, 31));
      alarm_ack = ($urandom % 12) == 0;
      alarm_arm = ($urandom % 4) != 0;
      if (k % 25 == 0) begin
        int t;
        t = (m_tod + 1) % DAY;
        alarm_sec = 6'(t % 60); alarm_min = 6'((t / 60) % 60); alarm_hour = 5'(t / 3600);
      end
      if (load && ($urandom % 2) == 0) begin
        load_sec = 6'd59; load_min = 6'd59; load_hour = 5'($urandom_range(22, 23));
      end
      step("random");
    end
    clear = 1'b0; load = 1'b0; alarm_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
